// File: rtl/hilo_ctrl.sv
// HI/LO register controller: sequences an external multi-cycle unsigned multiplier
// and serves move-to / move-from HI/LO requests from the EX stage.
module hilo_ctrl #(
  parameter int unsigned MUL_LATENCY = 33,
  parameter logic [5:0]  MULTU       = 6'b011001,
  parameter logic [5:0]  MFHI        = 6'b010000,
  parameter logic [5:0]  MTHI        = 6'b010001,
  parameter logic [5:0]  MFLO        = 6'b010010,
  parameter logic [5:0]  MTLO        = 6'b010011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  funct,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [63:0] mul_result,
  output logic [5:0]  mul_signal,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        stall,
  output logic        busy,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned CNT_W = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RUN     = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               hilo_op_c;
  logic               accept_c;

  assign hilo_op_c = (funct == MULTU) || (funct == MFHI) || (funct == MFLO) ||
                     (funct == MTHI)  || (funct == MTLO);

  // Requests are only taken in IDLE; anything HI/LO-class arriving later is held off.
  assign stall    = !rst && start && hilo_op_c && (state != IDLE);
  assign accept_c = start && hilo_op_c && (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      hi         <= '0;
      lo         <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      mul_signal <= 6'b000000;
      busy       <= 1'b0;
    end else begin
      rd_valid   <= 1'b0;
      mul_signal <= 6'b000000;
      case (state)
        IDLE: begin
          if (accept_c) begin
            if (funct == MULTU) begin
              mul_a      <= rs_data;
              mul_b      <= rt_data;
              mul_signal <= MULTU;
              busy       <= 1'b1;
              state      <= ISSUE;
            end else if (funct == MTHI) begin
              hi <= rs_data;
            end else if (funct == MTLO) begin
              lo <= rs_data;
            end else if (funct == MFHI) begin
              rd_data  <= hi;
              rd_valid <= 1'b1;
            end else begin
              rd_data  <= lo;
              rd_valid <= 1'b1;
            end
          end
        end
        ISSUE: begin
          cnt   <= CNT_W'(MUL_LATENCY - 1);
          state <= RUN;
        end
        RUN: begin
          // Counter saturates at zero; reaching zero hands off to the capture cycle.
          if (cnt == '0) begin
            state <= CAPTURE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        CAPTURE: begin
          hi    <= mul_result[63:32];
          lo    <= mul_result[31:0];
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Bench for hilo_ctrl: directed scenarios plus randomized traffic, all checked
// every cycle against a transaction-level model of HI/LO and multiply timing.
module tb_hilo_ctrl;

  localparam int unsigned LAT     = 33;
  localparam logic [5:0]  F_MULTU = 6'b011001;
  localparam logic [5:0]  F_MFHI  = 6'b010000;
  localparam logic [5:0]  F_MTHI  = 6'b010001;
  localparam logic [5:0]  F_MFLO  = 6'b010010;
  localparam logic [5:0]  F_MTLO  = 6'b010011;
  localparam logic [5:0]  F_OTHER = 6'b100000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [63:0] mul_result;
  logic [5:0]  mul_signal;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        stall;
  logic        busy;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [31:0] hi;
  logic [31:0] lo;

  always #5 clk = ~clk;

  hilo_ctrl #(.MUL_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .funct(funct),
    .rs_data(rs_data), .rt_data(rt_data), .mul_result(mul_result),
    .mul_signal(mul_signal), .mul_a(mul_a), .mul_b(mul_b),
    .stall(stall), .busy(busy), .rd_data(rd_data), .rd_valid(rd_valid),
    .hi(hi), .lo(lo)
  );

  int checks   = 0;
  int failures = 0;

  // Model: a multiply occupies the unit for LAT+2 cycles, then commits its product.
  int          busy_left = 0;
  logic [31:0] m_hi = '0, m_lo = '0, m_rd = '0, m_a = '0, m_b = '0;
  logic        m_rdv = 1'b0;
  logic [5:0]  m_sig = '0;
  logic [63:0] m_prod = '0;
  logic        last_stall = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_op(input logic [5:0] f);
    return (f == F_MULTU) || (f == F_MFHI) || (f == F_MFLO) || (f == F_MTHI) || (f == F_MTLO);
  endfunction

  task automatic step(input logic r, input logic s, input logic [5:0] f,
                      input logic [31:0] a, input logic [31:0] b);
    logic exp_stall;
    @(negedge clk);
    rst = r; start = s; funct = f; rs_data = a; rt_data = b;
    mul_result = (busy_left > 0) ? m_prod : {$urandom, $urandom};
    #1;
    exp_stall = !r && s && is_op(f) && (busy_left > 0);
    chk("stall", 64'(stall), 64'(exp_stall));
    last_stall = stall;
    @(posedge clk);
    if (r) begin
      busy_left = 0; m_hi = '0; m_lo = '0; m_rd = '0; m_a = '0; m_b = '0; m_rdv = 1'b0;
    end else begin
      m_rdv = 1'b0;
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          m_hi = m_prod[63:32];
          m_lo = m_prod[31:0];
        end
      end else if (s && is_op(f)) begin
        if (f == F_MULTU) begin
          busy_left = int'(LAT) + 2;
          m_a = a; m_b = b;
          m_prod = 64'(a) * 64'(b);
        end else if (f == F_MTHI) m_hi = a;
        else if (f == F_MTLO) m_lo = a;
        else if (f == F_MFHI) begin m_rd = m_hi; m_rdv = 1'b1; end
        else begin m_rd = m_lo; m_rdv = 1'b1; end
      end
    end
    m_sig = (!r && busy_left == int'(LAT) + 2) ? F_MULTU : 6'b000000;
    #1;
    chk("hi", 64'(hi), 64'(m_hi));
    chk("lo", 64'(lo), 64'(m_lo));
    chk("busy", 64'(busy), 64'(busy_left > 0));
    chk("rd_valid", 64'(rd_valid), 64'(m_rdv));
    chk("rd_data", 64'(rd_data), 64'(m_rd));
    chk("mul_signal", 64'(mul_signal), 64'(m_sig));
    chk("mul_a", 64'(mul_a), 64'(m_a));
    chk("mul_b", 64'(mul_b), 64'(m_b));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 6'b000000, '0, '0);
  endtask

  initial begin
    int          bc;
    int          n;
    int          stalls;
    logic        saw12;
    logic        cs;
    logic [5:0]  cf;
    logic [31:0] ca, cb;

    rst = 1'b1; start = 1'b0; funct = '0; rs_data = '0; rt_data = '0; mul_result = '0;
    step(1'b1, 1'b0, 6'b000000, '0, '0);
    step(1'b1, 1'b1, F_MTHI, 32'hDEADBEEF, '0);
    chk("reset_busy", 64'(busy), 64'(0));

    // Single multiply: one issue cycle, 35 busy cycles, product 0x1_FFFFFFFE.
    step(1'b0, 1'b1, F_MULTU, 32'hFFFFFFFF, 32'd2);
    bc = busy ? 1 : 0;
    for (int i = 0; i < 36; i++) begin
      step(1'b0, 1'b0, 6'b000000, '0, '0);
      if (busy) bc++;
    end
    chk("mul_busy_cycles", 64'(bc), 64'(35));
    chk("mul_hi", 64'(hi), 64'h1);
    chk("mul_lo", 64'(lo), 64'hFFFFFFFE);

    // Move-to then move-from.
    step(1'b0, 1'b1, F_MTHI, 32'h12345678, '0);
    step(1'b0, 1'b1, F_MTLO, 32'h9ABCDEF0, '0);
    step(1'b0, 1'b1, F_MFHI, '0, '0);
    chk("mfhi_data", 64'(rd_data), 64'h12345678);
    step(1'b0, 1'b1, F_MFLO, '0, '0);
    chk("mflo_data", 64'(rd_data), 64'h9ABCDEF0);
    step(1'b0, 1'b0, F_MFLO, '0, '0);
    chk("rd_hold", 64'(rd_data), 64'h9ABCDEF0);

    // MFLO held during a multiply returns the fresh product.
    step(1'b0, 1'b1, F_MULTU, 32'd7, 32'd9);
    n = 0;
    do begin
      step(1'b0, 1'b1, F_MFLO, '0, '0);
      n++;
    end while (!rd_valid && n < 60);
    chk("mflo_after_mul_valid", 64'(rd_valid), 64'(1));
    chk("mflo_after_mul_data", 64'(rd_data), 64'd63);
    chk("mflo_wait_cycles", 64'(n), 64'(LAT + 3));

    // Reset 10 cycles into RUN aborts the multiply.
    step(1'b0, 1'b1, F_MULTU, 32'd123, 32'd456);
    idle(11);
    step(1'b1, 1'b0, 6'b000000, '0, '0);
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_hi", 64'(hi), 64'(0));
    idle(40);
    chk("abort_lo_later", 64'(lo), 64'(0));

    // Back-to-back multiplies.
    step(1'b0, 1'b1, F_MULTU, 32'd3, 32'd4);
    stalls = 0; saw12 = 1'b0; n = 0;
    do begin
      step(1'b0, 1'b1, F_MULTU, 32'd5, 32'd6);
      if (last_stall) stalls++;
      if (lo == 32'd12) saw12 = 1'b1;
      n++;
    end while (last_stall && n < 60);
    chk("b2b_stalls", 64'(stalls), 64'(35));
    chk("b2b_mid_lo", 64'(saw12), 64'(1));
    idle(36);
    chk("b2b_final", {32'(hi), 32'(lo)}, 64'd30);

    // Non-HI/LO funct is ignored.
    step(1'b0, 1'b1, F_OTHER, 32'h55, 32'h66);
    chk("other_busy", 64'(busy), 64'(0));

    // Randomized traffic; a stalled request is held by EX.
    cs = 1'b0; cf = '0; ca = '0; cb = '0;
    for (int i = 0; i < 4000; i++) begin
      if (!last_stall) begin
        cs = ($urandom_range(0, 2) != 0);
        case ($urandom_range(0, 7))
          0, 1:    cf = F_MULTU;
          2:       cf = F_MFHI;
          3:       cf = F_MFLO;
          4:       cf = F_MTHI;
          5:       cf = F_MTLO;
          6:       cf = F_OTHER;
          default: cf = 6'($urandom);
        endcase
        ca = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
        cb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      end
      step(($urandom_range(0, 149) == 0), cs, cf, ca, cb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
